// File: rtl/fofb_xy_capture.sv
// fofb_xy_capture
//   Captures per-BPM X/Y position packets from the FOFB communication
//   controller receive path into a ping-pong buffer indexed by BPM id, and
//   presents the last completed timeframe to the PCIe DMA engine.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   fofb_rxlink_up_i    CC receive link up; packets/timeframe ends ignored when low
//   pkt_valid_i         one-cycle strobe, packet fields valid
//   pkt_bpmid_i         BPM id (buffer address)
//   pkt_xpos_i/ypos_i   X / Y position, stored as {X, Y}
//   timeframe_end_i     one-cycle strobe marking end of timeframe (bank swap)
//   xy_buf_addr_i       DMA read address
//   xy_buf_dat_o        read data of the completed bank, 1-cycle latency,
//                       zero for BPMs not received in that frame
//   timeframe_end_o     one-cycle pulse, completed bank ready to read
//   frame_pkt_cnt_o     distinct BPMs written in the last completed frame
//   frame_cnt_o         completed frame count (wraps)
//   dup_cnt_o           duplicate-id packets since reset (saturating)
module fofb_xy_capture #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fofb_rxlink_up_i,
  input  logic                  pkt_valid_i,
  input  logic [9:0]            pkt_bpmid_i,
  input  logic [31:0]           pkt_xpos_i,
  input  logic [31:0]           pkt_ypos_i,
  input  logic                  timeframe_end_i,
  input  logic [ADDR_WIDTH-1:0] xy_buf_addr_i,
  output logic [DATA_WIDTH-1:0] xy_buf_dat_o,
  output logic                  timeframe_end_o,
  output logic [ADDR_WIDTH:0]   frame_pkt_cnt_o,
  output logic [31:0]           frame_cnt_o,
  output logic [15:0]           dup_cnt_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  // Both banks live in one RAM; the bank select is the address MSB.
  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  logic                  wr_bank_q;
  logic [1:0][DEPTH-1:0] valid_q;
  logic [CNT_W-1:0]      run_cnt_q;
  logic [CNT_W-1:0]      run_cnt_d;
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic                  rd_valid_q;
  logic                  tf_end_q;
  logic [CNT_W-1:0]      frame_pkt_cnt_q;
  logic [31:0]           frame_cnt_q;
  logic [15:0]           dup_cnt_q;

  logic                  pkt_acc;
  logic                  tf_acc;
  logic                  pkt_dup;
  logic [ADDR_WIDTH-1:0] pkt_id;

  always_comb begin
    pkt_acc   = pkt_valid_i && fofb_rxlink_up_i;
    tf_acc    = timeframe_end_i && fofb_rxlink_up_i;
    pkt_id    = pkt_bpmid_i[ADDR_WIDTH-1:0];
    pkt_dup   = pkt_acc && valid_q[wr_bank_q][pkt_id];
    run_cnt_d = run_cnt_q;
    if (pkt_acc && !pkt_dup) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end
  end

  // RAM: no reset so it maps onto block RAM. Stale contents are masked by
  // the valid bitmap, so they never need clearing.
  always_ff @(posedge clk) begin
    if (pkt_acc) begin
      mem[{wr_bank_q, pkt_id}] <= {pkt_xpos_i, pkt_ypos_i};
    end
    ram_rd_q <= mem[{~wr_bank_q, xy_buf_addr_i}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q       <= 1'b0;
      valid_q         <= '0;
      run_cnt_q       <= '0;
      rd_valid_q      <= 1'b0;
      tf_end_q        <= 1'b0;
      frame_pkt_cnt_q <= '0;
      frame_cnt_q     <= '0;
      dup_cnt_q       <= '0;
    end else begin
      // Valid bit sampled alongside the RAM read so qualifier and data
      // refer to the same bank and address.
      rd_valid_q <= valid_q[~wr_bank_q][xy_buf_addr_i];
      tf_end_q   <= tf_acc;

      // A packet coincident with the swap targets the old write bank while
      // the clear targets the other bank, so both updates can coexist.
      if (pkt_acc) begin
        valid_q[wr_bank_q][pkt_id] <= 1'b1;
      end
      if (pkt_dup && (dup_cnt_q != '1)) begin
        dup_cnt_q <= dup_cnt_q + 16'd1;
      end

      if (tf_acc) begin
        valid_q[~wr_bank_q] <= '0;
        wr_bank_q           <= ~wr_bank_q;
        frame_pkt_cnt_q     <= run_cnt_d;
        run_cnt_q           <= '0;
        frame_cnt_q         <= frame_cnt_q + 32'd1;
      end else begin
        run_cnt_q <= run_cnt_d;
      end
    end
  end

  assign xy_buf_dat_o    = rd_valid_q ? ram_rd_q : '0;
  assign timeframe_end_o = tf_end_q;
  assign frame_pkt_cnt_o = frame_pkt_cnt_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign dup_cnt_o       = dup_cnt_q;

endmodule

// File: tb/tb_fofb_xy_capture.sv
// Scoreboard bench for fofb_xy_capture: the driver pushes expected read data
// and expected end-of-frame status; monitors pop and compare when the DUT
// presents read data or a timeframe_end_o pulse.
module tb_fofb_xy_capture;

  typedef struct packed {
    logic [10:0] pkt_cnt;
    logic [31:0] frm_cnt;
    logic [15:0] dup_cnt;
  } status_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_up = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [9:0]  pkt_id = '0;
  logic [31:0] pkt_x = '0;
  logic [31:0] pkt_y = '0;
  logic        tf_end = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_dat;
  logic        tf_end_o;
  logic [10:0] frame_pkt_cnt;
  logic [31:0] frame_cnt;
  logic [15:0] dup_cnt;

  logic        rd_req = 1'b0;
  logic        rd_req_q = 1'b0;

  logic [63:0] exp_rd_q [$];
  status_t     exp_st_q [$];

  int unsigned total = 0;
  int unsigned bad = 0;

  fofb_xy_capture #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .fofb_rxlink_up_i (link_up),
    .pkt_valid_i      (pkt_valid),
    .pkt_bpmid_i      (pkt_id),
    .pkt_xpos_i       (pkt_x),
    .pkt_ypos_i       (pkt_y),
    .timeframe_end_i  (tf_end),
    .xy_buf_addr_i    (rd_addr),
    .xy_buf_dat_o     (rd_dat),
    .timeframe_end_o  (tf_end_o),
    .frame_pkt_cnt_o  (frame_pkt_cnt),
    .frame_cnt_o      (frame_cnt),
    .dup_cnt_o        (dup_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_req_q <= rd_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Read-data monitor: data for an address sampled at edge N is valid
  // after edge N, checked on the following falling edge.
  always @(negedge clk) begin
    if (rd_req_q) begin
      if (exp_rd_q.size() == 0) begin
        chk("rd_unexpected", 64'd1, 64'd0);
      end else begin
        chk("rd_data", rd_dat, exp_rd_q.pop_front());
      end
    end
  end

  // Frame-end monitor: any pulse must match a queued expected status.
  always @(negedge clk) begin
    if (tf_end_o) begin
      if (exp_st_q.size() == 0) begin
        chk("tf_unexpected", 64'd1, 64'd0);
      end else begin
        chk("tf_status", {5'd0, frame_pkt_cnt, frame_cnt, dup_cnt}, {5'd0, exp_st_q.pop_front()});
      end
    end
  end

  function automatic status_t mkst(input int unsigned c, input int unsigned f, input int unsigned d);
    mkst.pkt_cnt = 11'(c);
    mkst.frm_cnt = f;
    mkst.dup_cnt = 16'(d);
  endfunction

  task automatic pkt(input int unsigned id, input logic [31:0] x, input logic [31:0] y);
    pkt_valid = 1'b1;
    pkt_id    = 10'(id);
    pkt_x     = x;
    pkt_y     = y;
  endtask

  task automatic tfe(input status_t st);
    tf_end = 1'b1;
    if (link_up) exp_st_q.push_back(st);
  endtask

  task automatic rd(input int unsigned a, input logic [63:0] exp);
    rd_addr = 10'(a);
    rd_req  = 1'b1;
    exp_rd_q.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    tf_end    = 1'b0;
    rd_req    = 1'b0;
  endtask

  task automatic chk_outs(input string name, input int unsigned c, input int unsigned f, input int unsigned d);
    chk({name, "_pktcnt"}, 64'(frame_pkt_cnt), 64'(c));
    chk({name, "_frmcnt"}, 64'(frame_cnt), 64'(f));
    chk({name, "_dupcnt"}, 64'(dup_cnt), 64'(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_dat", rd_dat, 64'd0);
    chk("rst_tfo", 64'(tf_end_o), 64'd0);
    chk_outs("rst", 0, 0, 0);
    rd(0, 64'd0); tick();
    rd(3, 64'd0); tick();

    // Basic frame
    pkt(3, 32'h11, 32'h22); tick();
    pkt(1023, 32'hAAAA5555, 32'h1); tick();
    tfe(mkst(2, 1, 0)); tick();
    rd(3, 64'h0000001100000022); tick();
    rd(1023, 64'hAAAA555500000001); tick();
    rd(5, 64'd0); tick();

    // Duplicate id in one frame: last write wins
    pkt(7, 32'h1, 32'h0); tick();
    pkt(7, 32'h2, 32'h0); tick();
    tfe(mkst(1, 2, 1)); tick();
    rd(7, 64'h0000000200000000); tick();
    rd(3, 64'd0); tick();

    // Stale entries cleared between frames
    pkt(9, 32'h9, 32'h9); tick();
    tfe(mkst(1, 3, 1)); tick();
    pkt(10, 32'hA, 32'hB); tick();
    tfe(mkst(1, 4, 1)); tick();
    rd(9, 64'd0); tick();
    rd(7, 64'd0); tick();
    rd(10, 64'h0000000A0000000B); tick();

    // Packet coincident with timeframe end belongs to the ending frame
    pkt(6, 32'h6, 32'h66); tick();
    pkt(4, 32'h4, 32'h44); tfe(mkst(2, 5, 1)); tick();
    rd(4, 64'h0000000400000044); tick();
    rd(6, 64'h0000000600000066); tick();

    // Link down: partial frame kept, nothing else changes
    pkt(20, 32'h20, 32'h21); tick();
    link_up = 1'b0;
    pkt(21, 32'hDEAD, 32'hBEEF); tick();
    pkt(20, 32'hFF, 32'hFF); tick();
    tfe(mkst(0, 0, 0)); tick();
    rd(4, 64'h0000000400000044); tick();
    tick(); tick();
    chk("lnk_tfo", 64'(tf_end_o), 64'd0);
    chk_outs("lnk", 2, 5, 1);
    link_up = 1'b1;
    pkt(22, 32'h22, 32'h23); tick();
    // Read in swap cycle returns the pre-swap bank
    rd(4, 64'h0000000400000044); tfe(mkst(2, 6, 1)); tick();
    rd(4, 64'd0); tick();
    rd(20, 64'h0000002000000021); tick();
    rd(21, 64'd0); tick();
    rd(22, 64'h0000002200000023); tick();

    // Empty frame
    tfe(mkst(0, 7, 1)); tick();
    rd(20, 64'd0); tick();
    tick(); tick();

    // Reset mid-frame discards the partial frame
    pkt(30, 32'h30, 32'h31); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mrst_tfo", 64'(tf_end_o), 64'd0);
    chk_outs("mrst", 0, 0, 0);
    rd(30, 64'd0); tick();
    tfe(mkst(0, 1, 0)); tick();
    rd(30, 64'd0); tick();

    repeat (4) tick();
    chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    chk("tf_queue_drained", 64'(exp_st_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fofb_xy_capture.md
Name: fofb_xy_capture

Overview:
- Captures per-BPM X/Y position packets from the FOFB communication controller receive path into a ping-pong buffer indexed by BPM id.
- Presents the last completed timeframe to the PCIe bus-master DMA engine through a read port with 1-cycle latency.
- Sits directly upstream of the bus-master device:
  - its read port serves that device's xy_buf_addr/xy_buf_dat;
  - its timeframe_end_o drives that device's timeframe_end input.
- Bank swap happens on each timeframe end. Per-entry valid bitmaps make entries for BPMs not received in a frame read back as zero.

Parameters:
- ADDR_WIDTH, 10, BPM id / buffer address width; DEPTH = 2^ADDR_WIDTH entries per bank.
- DATA_WIDTH, 64, stored word width; X in [63:32], Y in [31:0].

Ports:
- clk  input  1  single clock for all logic (CC user clock domain, crossed upstream).
- rst  input  1  synchronous, active-high reset.
- fofb_rxlink_up_i  input  1  CC receive link up; when low, packets and timeframe ends are ignored.
- pkt_valid_i  input  1  one-cycle strobe; packet fields valid.
- pkt_bpmid_i  input  10  BPM id of packet.
- pkt_xpos_i  input  32  X position.
- pkt_ypos_i  input  32  Y position.
- timeframe_end_i  input  1  one-cycle strobe from CC marking end of timeframe.
- xy_buf_addr_i  input  ADDR_WIDTH  read address from DMA engine.
- xy_buf_dat_o  output  DATA_WIDTH  read data, completed bank.
- timeframe_end_o  output  1  one-cycle pulse; completed bank ready to read.
- frame_pkt_cnt_o  output  ADDR_WIDTH+1  distinct BPMs written in last completed frame.
- frame_cnt_o  output  32  count of completed frames.
- dup_cnt_o  output  16  duplicate-id packets since reset (saturating).

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_bank=0; both valid bitmaps cleared; running packet count=0.
  - xy_buf_dat_o=0, timeframe_end_o=0, frame_pkt_cnt_o=0, frame_cnt_o=0, dup_cnt_o=0.
  - Reset mid-frame discards that frame; no timeframe_end_o is issued for it.
- Storage:
  - two banks of DEPTH x DATA_WIDTH (block RAM, one write port, one read port);
  - two DEPTH-bit valid bitmaps (flops).
  - Write bank = wr_bank; read bank = ~wr_bank.
- Packet write: when pkt_valid_i && fofb_rxlink_up_i:
  - write {xpos,ypos} at pkt_bpmid_i in the write bank;
  - set valid[wr_bank][id].
  - If the valid bit was already set: last write wins, running count unchanged, dup_cnt_o++ (saturate at 16'hFFFF).
  - Otherwise running count++.
- Ids: pkt_bpmid_i is truncated to ADDR_WIDTH bits; with the default ADDR_WIDTH=10 every id is in range.
- Swap: on timeframe_end_i && fofb_rxlink_up_i at edge N:
  - wr_bank toggles;
  - frame_pkt_cnt_o <= running count (including any packet written at edge N);
  - running count <= 0;
  - new write bank's valid bitmap cleared in the same edge;
  - frame_cnt_o++ (wraps at 2^32);
  - timeframe_end_o=1 for the cycle following edge N.
- Simultaneous packet and timeframe_end_i in the same cycle: the packet belongs to the ending frame and is written to the old bank and counted before the swap.
- timeframe_end_i with zero packets still swaps; frame_pkt_cnt_o=0.
- Link down (fofb_rxlink_up_i=0):
  - no writes, no swaps, no counter changes;
  - the read bank stays stable and readable;
  - a partial frame in the write bank is kept and resumes when the link returns.
- Read: xy_buf_dat_o registered, 1-cycle latency.
  - Equals the RAM word of the read bank at the address presented on the previous edge if its valid bit is set, else 0.
  - The valid bit is sampled with the address so data and qualifier align.
  - A read issued in the swap cycle returns the pre-swap read bank; the next read uses the new bank.
- Consumer rule (not checked in RTL): the DMA engine finishes reading a frame before the next timeframe_end_o; otherwise it reads a mixture of frames.

Test Plan:
- Reset: hold rst 2 cycles -> all outputs 0; read any address -> 0.
- Basic frame: packets id 3 (X=0x11,Y=0x22) and id 1023 (X=0xAAAA5555,Y=0x1), then timeframe_end_i -> timeframe_end_o pulses 1 cycle later, frame_pkt_cnt_o=2, frame_cnt_o=1; read addr 3 -> 0x0000001100000022 next cycle; addr 1023 -> 0xAAAA555500000001; addr 5 -> 0.
- Duplicate: id 7 twice (X=1 then X=2) in one frame -> frame_pkt_cnt_o=1, dup_cnt_o=1, addr 7 reads X=2.
- Stale clear: frame A writes id 9, frame B writes only id 10 -> after B, addr 9 reads 0, addr 10 valid, frame_cnt_o=2.
- Same-cycle edge: packet id 4 coincident with timeframe_end_i -> id 4 appears in the just-completed frame with frame_pkt_cnt_o counting it; next frame count starts at 0.
- Link down: deassert fofb_rxlink_up_i, send packets and timeframe_end_i -> no timeframe_end_o, counters and read data unchanged.
